// File: rtl/aer_event_receiver.sv
// aer_event_receiver: consumer end of the AER arbitration tree.
// Detects new grants from the top-level arbiter, stamps them with a
// free-running timestamp, buffers them in a first-word-fall-through FIFO
// and presents them to readout over valid/ready. The arbiter is throttled
// with hysteresis as the FIFO nears full, and the block drains to IDLE
// when disabled.
module aer_event_receiver #(
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int TS_W     = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          enable_i,
    input  logic                          active_i,
    input  logic [X_W-1:0]                x_add_i,
    input  logic [Y_W-1:0]                y_add_i,
    input  logic                          grp_release_i,
    output logic                          arb_enable_o,
    output logic                          event_valid_o,
    input  logic                          event_ready_i,
    output logic [1+TS_W+X_W+Y_W-1:0]     event_data_o,
    output logic [$clog2(DEPTH):0]        fifo_count_o,
    output logic                          overflow_o,
    output logic [7:0]                    drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = 1 + TS_W + X_W + Y_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        THROTTLE = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t          state;
    logic            active_q;
    logic [X_W-1:0]  x_q;
    logic [Y_W-1:0]  y_q;
    logic [TS_W-1:0] ts;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            new_evt;
    logic            capture;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push;
    logic            drop;

    // A grant is new when active rises or the granted address moves while
    // active stays high; a steady grant of one address is a single event.
    assign new_evt = active_i & (~active_q | (x_add_i != x_q) | (y_add_i != y_q));
    // Grants seen while idle or draining are deliberately ignored.
    assign capture = new_evt & ((state == RUN) | (state == THROTTLE));

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign pop   = ~empty & event_ready_i;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push  = capture & (~full | pop);
    assign drop  = capture & full & ~pop;

    assign event_valid_o = ~empty;
    // Forced to zero when empty so stale storage never reaches readout.
    assign event_data_o  = empty ? '0 : mem[rd_ptr];
    assign fifo_count_o  = count;

    // Register the arbiter inputs every cycle for edge/change detection.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            active_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
        end else begin
            active_q <= active_i;
            x_q      <= x_add_i;
            y_q      <= y_add_i;
        end
    end

    // Free-running timestamp, frozen only while IDLE; wraps silently.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ts <= '0;
        end else if (state != IDLE) begin
            ts <= ts + TS_W'(1);
        end
    end

    // FIFO storage write; the word carries the pre-edge timestamp.
    // NOTE: the storage array has no reset; validity is tracked by count,
    // so resetting it would only add muxes to every entry.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {grp_release_i, ts, x_add_i, y_add_i};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag and saturating count of dropped events.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (drop_cnt_o != 8'hFF) drop_cnt_o <= drop_cnt_o + 8'd1;
        end
    end

    // Control FSM with registered arbiter enable matching the next state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            arb_enable_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state        <= RUN;
                        arb_enable_o <= 1'b1;
                    end else begin
                        arb_enable_o <= 1'b0;
                    end
                end
                RUN: begin
                    if (!enable_i) begin
                        state        <= DRAIN;
                        arb_enable_o <= 1'b0;
                    end else if (count >= CW'(AF_LEVEL)) begin
                        state        <= THROTTLE;
                        arb_enable_o <= 1'b0;
                    end else begin
                        arb_enable_o <= 1'b1;
                    end
                end
                THROTTLE: begin
                    if (!enable_i) begin
                        state        <= DRAIN;
                        arb_enable_o <= 1'b0;
                    end else if (count <= CW'(AF_LEVEL - 2)) begin
                        state        <= RUN;
                        arb_enable_o <= 1'b1;
                    end else begin
                        arb_enable_o <= 1'b0;
                    end
                end
                default: begin  // DRAIN: always returns through IDLE
                    arb_enable_o <= 1'b0;
                    if (empty) state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aer_event_receiver.sv
// Self-checking bench for aer_event_receiver: directed scenarios followed
// by random traffic, checked by a queue-based reference model and a
// decoupled scoreboard monitor.
module tb_aer_event_receiver;

    localparam int X_W      = 4;
    localparam int Y_W      = 4;
    localparam int TS_W     = 16;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 6;
    localparam int DW       = 1 + TS_W + X_W + Y_W;

    typedef logic [DW-1:0] word_t;
    typedef enum {M_IDLE, M_RUN, M_THR, M_DRAIN} mode_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   enable = 1'b0;
    logic                   active = 1'b0;
    logic [X_W-1:0]         x = '0;
    logic [Y_W-1:0]         y = '0;
    logic                   grp = 1'b0;
    logic                   ready = 1'b0;
    logic                   arb_en;
    logic                   valid;
    word_t                  data;
    logic [$clog2(DEPTH):0] count;
    logic                   ovf;
    logic [7:0]             drops;

    int errors = 0;
    int checks = 0;

    // Reference model state
    word_t sb[$];
    mode_t m_mode  = M_IDLE;
    int    m_count = 0;
    int    m_ts    = 0;
    bit    m_aq    = 0;
    int    m_xq    = 0;
    int    m_yq    = 0;
    bit    m_ovf   = 0;
    int    m_drops = 0;
    bit    m_arb   = 0;

    aer_event_receiver #(
        .X_W(X_W), .Y_W(Y_W), .TS_W(TS_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (rst_n),
        .enable_i      (enable),
        .active_i      (active),
        .x_add_i       (x),
        .y_add_i       (y),
        .grp_release_i (grp),
        .arb_enable_o  (arb_en),
        .event_valid_o (valid),
        .event_ready_i (ready),
        .event_data_o  (data),
        .fifo_count_o  (count),
        .overflow_o    (ovf),
        .drop_cnt_o    (drops)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Behavioural model: a queue of expected words plus the control rules.
    initial begin : model
        bit pop_b, evt, cap, acc;
        int cnt_before;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                m_mode = M_IDLE; m_count = 0; m_ts = 0;
                m_aq = 0; m_xq = 0; m_yq = 0;
                m_ovf = 0; m_drops = 0; m_arb = 0;
            end else begin
                cnt_before = m_count;
                pop_b = (m_count > 0) && ready;
                evt   = active && (!m_aq || int'(x) != m_xq || int'(y) != m_yq);
                cap   = evt && (m_mode == M_RUN || m_mode == M_THR);
                acc   = cap && (m_count < DEPTH || pop_b);
                if (acc) sb.push_back({grp, m_ts[15:0], x, y});
                if (cap && !acc) begin
                    m_ovf = 1;
                    if (m_drops < 255) m_drops++;
                end
                m_count = m_count + int'(acc) - int'(pop_b);
                if (m_mode != M_IDLE) m_ts = (m_ts + 1) % 65536;
                case (m_mode)
                    M_IDLE:  if (enable) m_mode = M_RUN;
                    M_RUN:   if (!enable) m_mode = M_DRAIN;
                             else if (cnt_before >= AF_LEVEL) m_mode = M_THR;
                    M_THR:   if (!enable) m_mode = M_DRAIN;
                             else if (cnt_before <= AF_LEVEL - 2) m_mode = M_RUN;
                    M_DRAIN: if (cnt_before == 0) m_mode = M_IDLE;
                endcase
                m_arb = (m_mode == M_RUN);
                m_aq = active; m_xq = int'(x); m_yq = int'(y);
            end
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each
    // handshake the DUT is about to complete.
    initial begin : monitor
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                check("count", 32'(count), 32'(m_count));
                check("valid", 32'(valid), 32'(m_count > 0));
                check("arb_en", 32'(arb_en), 32'(m_arb));
                check("overflow", 32'(ovf), 32'(m_ovf));
                check("drop_cnt", 32'(drops), 32'(m_drops));
                if (valid && ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", 32'(valid), 32'(0));
                    end else begin
                        check("data", 32'(data), 32'(sb.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_empty(input string name);
        int n = 0;
        while (valid && n < 50) begin
            step();
            n++;
        end
        check(name, 32'(valid), 32'(0));
    endtask

    initial begin : stimulus
        int n;
        repeat (2) step();
        // Reset values while held in reset
        check("rst_arb", 32'(arb_en), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_data", 32'(data), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(ovf), 0);
        check("rst_drops", 32'(drops), 0);
        enable = 1'b1;
        rst_n  = 1'b1;

        // Single pulse sampled at ts=2
        repeat (3) step();
        active = 1'b1; x = 4'd3; y = 4'd5; grp = 1'b0;
        step();
        active = 1'b0;
        check("first_valid", 32'(valid), 1);
        check("first_data", 32'(data), 32'({1'b0, 16'd2, 4'd3, 4'd5}));
        check("first_count", 32'(count), 1);
        ready = 1'b1;
        step();
        check("first_popped", 32'(valid), 0);
        ready = 1'b0;

        // Held active with y = 1,2,2 -> two events
        step();
        active = 1'b1; x = 4'd0; y = 4'd1;
        step(); y = 4'd2;
        step(); y = 4'd2;
        step(); active = 1'b0;
        check("hold_two_events", 32'(count), 2);
        ready = 1'b1;
        wait_empty("hold_drain");
        ready = 1'b0;

        // Six events -> throttle one cycle later, release at count 4
        step();
        for (int i = 0; i < 6; i++) begin
            active = 1'b1; x = 4'd7; y = 4'(i);
            step();
        end
        active = 1'b0;
        check("af_count", 32'(count), 6);
        check("af_arb_still_on", 32'(arb_en), 1);
        step();
        check("af_throttled", 32'(arb_en), 0);
        ready = 1'b1;
        n = 0;
        while (!arb_en && n < 20) begin
            step();
            n++;
        end
        check("af_release_arb", 32'(arb_en), 1);
        check("af_release_count", 32'(count), 3);
        wait_empty("af_drain");
        ready = 1'b0;

        // Ten events -> 8 stored, 2 dropped, then push+pop while full
        step();
        for (int i = 0; i < 10; i++) begin
            active = 1'b1; x = 4'd9; y = 4'(i); grp = i[0];
            step();
        end
        check("ovf_count", 32'(count), 8);
        check("ovf_flag", 32'(ovf), 1);
        check("ovf_drops", 32'(drops), 2);
        y = 4'd12; ready = 1'b1;
        step();
        active = 1'b0; ready = 1'b0; grp = 1'b0;
        check("full_push_pop", 32'(count), 8);
        ready = 1'b1;
        wait_empty("ovf_drain");
        ready = 1'b0;
        repeat (4) step();

        // Drain on disable: further grants ignored, then IDLE
        for (int i = 0; i < 3; i++) begin
            active = 1'b1; x = 4'd2; y = 4'(i);
            step();
        end
        active = 1'b0;
        enable = 1'b0;
        step();
        check("drain_arb", 32'(arb_en), 0);
        active = 1'b1; x = 4'd15; y = 4'd15;
        step();
        active = 1'b0;
        step();
        check("drain_ignored", 32'(count), 3);
        ready = 1'b1;
        wait_empty("drain_empty");
        repeat (5) step();
        check("idle_arb", 32'(arb_en), 0);
        ready = 1'b0;
        enable = 1'b1;
        repeat (3) step();
        // Timestamp continuity after IDLE is checked by the scoreboard here
        active = 1'b1; x = 4'd1; y = 4'd1;
        step();
        active = 1'b0;

        // Mid-stream reset with 5 entries queued
        for (int i = 0; i < 4; i++) begin
            active = 1'b1; x = 4'd4; y = 4'(i);
            step();
        end
        active = 1'b0;
        check("pre_reset_count", 32'(count), 5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_arb", 32'(arb_en), 0);
        check("mid_rst_valid", 32'(valid), 0);
        check("mid_rst_data", 32'(data), 0);
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_ovf", 32'(ovf), 0);
        check("mid_rst_drops", 32'(drops), 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(valid), 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            active = ($urandom_range(0, 3) != 0);
            x      = 4'($urandom_range(0, 3));
            y      = 4'($urandom_range(0, 3));
            grp    = 1'($urandom_range(0, 1));
            ready  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            step();
        end
        active = 1'b0; enable = 1'b1; ready = 1'b1;
        wait_empty("final_drain");
        step();
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
